// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed MULT/DIV engine with HI/LO registers and done pulse.
// Define MULTDIV_EXCEPTION_EN to trap DIV by zero in one cycle with a div_zero pulse.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nx;
    logic op_r, sa, sb, trap, ge;
    logic [WIDTH-1:0] mag_a, mplr, abs_a, abs_b, rem_nx;
    logic [WIDTH:0] sum, rem_sh, diff;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [CW-1:0] cnt;
`ifdef MULTDIV_EXCEPTION_EN
    assign trap = op && b == '0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) div_zero <= 1'b0;
        else        div_zero <= state == IDLE && start && trap;
`else
    assign trap = 1'b0;
    assign div_zero = 1'b0;
`endif
    assign busy  = state != IDLE;
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;
    // mplr holds |b|: shifted as multiplier for MULT, static divisor for DIV
    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplr[0] ? {1'b0, mag_a} : '0);
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        ge     = rem_sh >= {1'b0, mplr};
        diff   = rem_sh - {1'b0, mplr};
        rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        acc_nx = op_r ? {rem_nx, acc[WIDTH-2:0], ge} : {sum, acc[WIDTH-1:1]};
    end
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? ((start && !trap) ? RUN : IDLE) :
                   state == RUN  ? ((cnt == CW'(WIDTH-1)) ? FIX : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            op_r  <= 1'b0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            mag_a <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                op_r  <= op;
                sa    <= a[WIDTH-1];
                sb    <= b[WIDTH-1];
                mag_a <= abs_a;
                mplr  <= abs_b;
                acc   <= {{WIDTH{1'b0}}, op ? abs_a : {WIDTH{1'b0}}};
                cnt   <= '0;
                done  <= trap;
            end else if (state == RUN) begin
                acc  <= acc_nx;
                mplr <= op_r ? mplr : mplr >> 1;
                cnt  <= cnt + 1'b1;
            end else if (state == FIX) begin
                done <= 1'b1;
                if (op_r) begin
                    hi <= sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    lo <= (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                end else
                    {hi, lo} <= (sa ^ sb) ? -acc : acc;
            end
        end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed scoreboard bench for mult_div_unit.
module tb_mult_div_unit;
    logic clk = 0, reset = 0, start = 0, op = 0;
    logic [31:0] a = 0, b = 0;
    logic busy, done, div_zero;
    logic [31:0] hi, lo;
    int pass_cnt = 0, fail_cnt = 0, total = 0, done_cnt = 0, d0;
    logic [64:0] sb_q[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic o, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz,
                          input int elat, input bit ign);
        int lat;
        logic [64:0] e;
        sb_q.push_back({edz, eh, el});
        @(negedge clk);
        start = 1; op = o; a = xa; b = xb;
        @(posedge clk);
        #1 start = 0; a = $urandom; b = $urandom;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
            if (ign && lat == 10) begin
                start = 1; op = 1'b0; a = 32'd3; b = 32'd3;
            end
            @(posedge clk);
            #1 lat++;
            start = 0;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        else begin
            e = sb_q.pop_front();
            chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
            chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
            chk({tag, "_dz"}, 64'(div_zero), 64'(e[64]));
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1 chk({tag, "_pulse"}, 64'({done, div_zero}), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk("rst_out", 64'({busy, done, div_zero}), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk) reset = 1;
        run_op("mul_neg", 1'b0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 0);
        run_op("mul_min", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 33, 0);
        run_op("div_neg", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 0);
        run_op("div_neg_b", 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33, 0);
        run_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33, 0);
`ifdef MULTDIV_EXCEPTION_EN
        run_op("div_zero", 1'b1, 32'd7, 32'd0, 32'h0, 32'h80000000, 1'b1, 0, 0);
`else
        run_op("div_zero", 1'b1, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b0, 33, 0);
`endif
        d0 = done_cnt;
        run_op("mul_ign", 1'b0, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 33, 1);
        repeat (3) @(posedge clk);
        #1 chk("one_done", 64'(done_cnt - d0), 64'd1);
        d0 = done_cnt;
        @(negedge clk);
        start = 1; op = 1; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 0;
        repeat (15) @(posedge clk);
        #1 reset = 0;
        #1 chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1;
        repeat (40) @(posedge clk);
        #1 chk("abort_nodone", 64'(done_cnt - d0), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
